// File: rtl/risc_mem_responder_if.sv
// Data-memory bus between the RISC core (master) and the memory responder (slave).
// The request fields are held by the master from cs rising until ready is seen.
interface risc_mem_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              cs;
   logic              rw;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              ready;
   logic              err;

   modport master (
      output cs, rw, address, data_in,
      input  data_out, ready, err
   );

   modport slave (
      input  cs, rw, address, data_in,
      output data_out, ready, err
   );
endinterface

// File: rtl/risc_mem_responder.sv
// Memory-side responder for the RISC data bus. It stores DEPTH words and answers
// each access after WAIT_STATES wait cycles. Completion is signalled with a
// one-cycle registered ready pulse, and err accompanies ready for out-of-range
// addresses. The memory array has no reset, so its contents survive rst.
module risc_mem_responder #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 200,
   parameter int WAIT_STATES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   risc_mem_responder_if.slave  bus
);

   localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [3:0]        cnt_r, cnt_nxt_s;
   logic              capture_s;
   logic              enter_resp_s;

   logic [ADDR_W-1:0] addr_r;
   logic              rw_r;
   logic [DATA_W-1:0] wdata_r;

   logic [ADDR_W-1:0] req_addr_s;
   logic              req_rw_s;
   logic [DATA_W-1:0] req_wdata_s;
   logic [IDX_W-1:0]  req_idx_s;
   logic              in_range_s;

   logic              ready_r;
   logic              err_r;
   logic [DATA_W-1:0] data_out_r;

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Next-state logic: accept in IDLE, count waits (abort if cs drops), one RESP cycle.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      capture_s    = 1'b0;
      enter_resp_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.cs) begin
               capture_s = 1'b1;
               cnt_nxt_s = WAIT_CNT;
               if (WAIT_CNT == 4'd0) begin
                  state_nxt_s  = ST_RESP;
                  enter_resp_s = 1'b1;
               end else begin
                  state_nxt_s  = ST_WAIT;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!bus.cs) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 4'd0;
            end else if (cnt_r == 4'd1) begin
               state_nxt_s  = ST_RESP;
               enter_resp_s = 1'b1;
               cnt_nxt_s    = 4'd0;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         ST_RESP: begin
            // Always return to IDLE; a still-high cs is picked up one cycle later.
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // Request view: live bus fields while accepting (zero-wait case), captured copy otherwise.
   always_comb begin
      if (state_r == ST_IDLE) begin
         req_addr_s  = bus.address;
         req_rw_s    = bus.rw;
         req_wdata_s = bus.data_in;
      end else begin
         req_addr_s  = addr_r;
         req_rw_s    = rw_r;
         req_wdata_s = wdata_r;
      end
   end

   // The full address is compared, so there is no aliasing above DEPTH.
   assign in_range_s = (32'(req_addr_s) < 32'(DEPTH));
   assign req_idx_s  = req_addr_s[IDX_W-1:0];

   // FSM state, wait counter and captured request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         addr_r  <= '0;
         rw_r    <= 1'b0;
         wdata_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (capture_s) begin
            addr_r  <= bus.address;
            rw_r    <= bus.rw;
            wdata_r <= bus.data_in;
         end
      end
   end

   // Registered response: ready/err pulse and read data, loaded on the edge entering RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_r    <= 1'b0;
         err_r      <= 1'b0;
         data_out_r <= '0;
      end else begin
         ready_r <= enter_resp_s;
         err_r   <= enter_resp_s & ~in_range_s;
         if (enter_resp_s && req_rw_s) begin
            data_out_r <= in_range_s ? mem_r[req_idx_s] : '0;
         end
      end
   end

   // Memory write commit on the edge entering RESP; a reset discards any pending write.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp_s && !req_rw_s && in_range_s) begin
         mem_r[req_idx_s] <= req_wdata_s;
      end
   end

   assign bus.ready    = ready_r;
   assign bus.err      = err_r;
   assign bus.data_out = data_out_r;

endmodule

// File: tb/tb_risc_mem_responder.sv
// Self-checking bench for risc_mem_responder: a WAIT_STATES=2 instance (dut_a) and a
// WAIT_STATES=0 instance (dut_b), checked against a word-array reference model.
module tb_risc_mem_responder;

   logic clk;
   logic rst;

   risc_mem_responder_if bus_a ();
   risc_mem_responder_if bus_b ();

   risc_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   risc_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: memory words, which were written, and last read data per instance
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   bit         wr_a  [256];
   logic [7:0] dout_a;
   logic [7:0] dout_b;
   logic [7:0] written_q [$];

   task automatic drive(input bit use_b, input logic cs, input logic rw,
                        input logic [7:0] a, input logic [7:0] d);
      if (use_b) begin
         bus_b.cs = cs; bus_b.rw = rw; bus_b.address = a; bus_b.data_in = d;
      end else begin
         bus_a.cs = cs; bus_a.rw = rw; bus_a.address = a; bus_a.data_in = d;
      end
   endtask

   // {ready, err, data_out} of the selected instance
   function automatic logic [9:0] sample(input bit use_b);
      if (use_b) return {bus_b.ready, bus_b.err, bus_b.data_out};
      else       return {bus_a.ready, bus_a.err, bus_a.data_out};
   endfunction

   // One complete access, entered and left at a negedge. When scramble is set the
   // request fields are changed after the capture edge; the responder must ignore them.
   task automatic access(input bit use_b, input bit rd, input logic [7:0] addr,
                         input logic [7:0] wd, input bit scramble, input string tag);
      int         exp_lat;
      int         lat;
      bit         seen;
      bit         early_err;
      bit         exp_e;
      logic [7:0] exp_d;
      logic [9:0] s;
      exp_lat = use_b ? 1 : 3;
      exp_e   = (addr >= 8'd200);
      if (rd) exp_d = exp_e ? 8'h00 : (use_b ? mem_b[addr] : mem_a[addr]);
      else    exp_d = use_b ? dout_b : dout_a;
      if (!rd && !exp_e) begin
         if (use_b) mem_b[addr] = wd;
         else begin mem_a[addr] = wd; wr_a[addr] = 1'b1; end
      end
      if (use_b) dout_b = exp_d; else dout_a = exp_d;

      drive(use_b, 1'b1, rd, addr, wd);
      seen = 1'b0; lat = 0; early_err = 1'b0;
      for (int i = 1; i <= 12 && !seen; i++) begin
         @(posedge clk);
         @(negedge clk);
         s = sample(use_b);
         if (s[9]) begin
            seen = 1'b1; lat = i;
         end else begin
            if (s[8]) early_err = 1'b1;
            if (scramble) drive(use_b, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
         end
      end
      checks++;
      if (!seen || lat != exp_lat) begin
         failures++;
         $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", tag, lat, seen, exp_lat);
      end
      checks++;
      if (s[8] !== exp_e || early_err) begin
         failures++;
         $display("FAIL %s err: got %b (err without ready=%0d) expected %b", tag, s[8], early_err, exp_e);
      end
      checks++;
      if (s[7:0] !== exp_d) begin
         failures++;
         $display("FAIL %s data_out: got %h expected %h", tag, s[7:0], exp_d);
      end
      drive(use_b, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      s = sample(use_b);
      checks++;
      if (s[9:8] !== 2'b00 || s[7:0] !== exp_d) begin
         failures++;
         $display("FAIL %s after_pulse: ready/err=%b data=%h expected 00 data=%h", tag, s[9:8], s[7:0], exp_d);
      end
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (sample(1'b0) !== 10'h000 || sample(1'b1) !== 10'h000) begin
         failures++;
         $display("FAIL reset_outputs: a=%h b=%h expected 000", sample(1'b0), sample(1'b1));
      end
      rst = 1'b0;
      dout_a = 8'h00; dout_b = 8'h00;
      @(negedge clk);
   endtask

   task automatic test_directed();
      access(1'b0, 1'b0, 8'h10, 8'hA5, 1'b0, "wr_10");
      access(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, "rd_10");
      access(1'b0, 1'b0, 8'h11, 8'h5C, 1'b0, "wr_11");
      access(1'b0, 1'b0, 8'h20, 8'h11, 1'b0, "wr_20");
      access(1'b0, 1'b0, 8'h30, 8'h44, 1'b0, "wr_30");
      access(1'b0, 1'b0, 8'hC8, 8'hEE, 1'b0, "wr_oor");
      access(1'b0, 1'b1, 8'hC8, 8'h00, 1'b0, "rd_oor");
      access(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, "rd_ff");
      access(1'b0, 1'b1, 8'hC7, 8'h00, 1'b0, "rd_c7_unwritten_skip") ;
   endtask

   task automatic test_abort();
      bit pulsed = 1'b0;
      logic [9:0] s;
      drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h3C);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         s = sample(1'b0);
         if (s[9] || s[8] || s[7:0] !== dout_a) pulsed = 1'b1;
      end
      checks++;
      if (pulsed) begin
         failures++;
         $display("FAIL abort_no_ready: saw ready/err or data change, last=%h expected data %h", s, dout_a);
      end
      access(1'b0, 1'b1, 8'h20, 8'h00, 1'b0, "rd_20_after_abort");
   endtask

   task automatic test_back_to_back();
      int         p1 = -1;
      int         p2 = -1;
      bit         held_bad = 1'b0;
      logic [9:0] s;
      drive(1'b0, 1'b1, 1'b1, 8'h10, 8'h00);
      for (int i = 1; i <= 15 && p2 < 0; i++) begin
         @(posedge clk);
         @(negedge clk);
         s = sample(1'b0);
         if (s[9]) begin
            if (p1 < 0) begin
               p1 = i;
               checks++;
               if (s[7:0] !== mem_a[8'h10]) begin
                  failures++;
                  $display("FAIL b2b_first_data: got %h expected %h", s[7:0], mem_a[8'h10]);
               end
               drive(1'b0, 1'b1, 1'b1, 8'h11, 8'h00);
            end else begin
               p2 = i;
            end
         end else if (p1 >= 0 && s[7:0] !== mem_a[8'h10]) begin
            held_bad = 1'b1;
         end
      end
      checks++;
      if (p1 < 0 || p2 < 0 || p2 - p1 != 4) begin
         failures++;
         $display("FAIL b2b_spacing: pulses at %0d and %0d expected 4 apart", p1, p2);
      end
      checks++;
      if (s[7:0] !== mem_a[8'h11] || held_bad) begin
         failures++;
         $display("FAIL b2b_second_data: got %h (hold broken=%0d) expected %h", s[7:0], held_bad, mem_a[8'h11]);
      end
      dout_a = mem_a[8'h11];
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
   endtask

   task automatic test_random();
      int         kind;
      logic [7:0] a;
      for (int n = 0; n < 40; n++) begin
         kind = (written_q.size() == 0) ? 0 : int'($urandom_range(0, 3));
         case (kind)
            0, 1: begin
               a = 8'($urandom_range(8'h40, 8'hC7));
               if (!wr_a[a]) written_q.push_back(a);
               access(1'b0, 1'b0, a, 8'($urandom), 1'b1, "rand_wr");
            end
            2: begin
               a = written_q[$urandom_range(0, written_q.size() - 1)];
               access(1'b0, 1'b1, a, 8'h00, 1'b1, "rand_rd");
            end
            default: begin
               a = 8'($urandom_range(200, 255));
               access(1'b0, 1'($urandom), a, 8'($urandom), 1'b1, "rand_oor");
            end
         endcase
      end
   endtask

   task automatic test_reset_mid_wait();
      access(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, "rd_10_pre_rst");
      drive(1'b0, 1'b1, 1'b0, 8'h30, 8'h77);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      checks++;
      if (sample(1'b0) !== 10'h000) begin
         failures++;
         $display("FAIL mid_wait_reset: got %h expected 000", sample(1'b0));
      end
      @(negedge clk);
      rst = 1'b0;
      dout_a = 8'h00; dout_b = 8'h00;
      @(negedge clk);
      access(1'b0, 1'b1, 8'h30, 8'h00, 1'b0, "rd_30_after_rst");
      access(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, "rd_10_after_rst");
   endtask

   task automatic test_zero_wait();
      access(1'b1, 1'b0, 8'h05, 8'h5A, 1'b0, "zw_wr_05");
      access(1'b1, 1'b1, 8'h05, 8'h00, 1'b0, "zw_rd_05");
      access(1'b1, 1'b1, 8'hC8, 8'h00, 1'b0, "zw_rd_oor");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) wr_a[i] = 1'b0;
      test_reset();
      test_directed();
      test_abort();
      test_back_to_back();
      test_random();
      test_reset_mid_wait();
      test_zero_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
